// File: rtl/conv_pkg.sv
// Shared defaults, burstcount sizing and reader FSM states for the convolution line path.
// No logic and no latency; constants only.
package conv_pkg;
    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LEN_W      = 16;
    localparam int DEF_BURST_MAX  = 8;
    localparam int DEF_FIFO_DEPTH = 32;

    // Avalon burstcount must be able to express BURST_MAX itself, not just BURST_MAX-1.
    function automatic int burstcount_w(input int burst_max);
        return $clog2(burst_max) + 1;
    endfunction

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/line_fifo.sv
// First-word-fall-through FIFO: a pushed word is visible on rdata the cycle after the push.
// Pushes are dropped when full and pops when empty; count holds on a simultaneous push and pop.
module line_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wdata,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rdata,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty,
    output logic                          full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/ddr_line_reader.sv
// Burst-reads one line from DDR into a FWFT FIFO and streams it out; first word appears one cycle after its readdatavalid.
// Reads are only requested when FIFO space minus in-flight words covers the burst, so out_ready backpressure never overflows.
module ddr_line_reader
    import conv_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int BURST_MAX  = DEF_BURST_MAX,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         clock_source,
    input  logic                         global_reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ADDR_W-1:0]            cmd_base_addr,
    input  logic [LEN_W-1:0]             cmd_words,
    output logic [ADDR_W-1:0]            avm_address,
    output logic                         avm_read,
    output logic [$clog2(BURST_MAX):0]   avm_burstcount,
    input  logic                         avm_waitrequest,
    input  logic [DATA_W-1:0]            avm_readdata,
    input  logic                         avm_readdatavalid,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);
    localparam int BC_W  = burstcount_w(BURST_MAX);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SHIFT = $clog2(DATA_W / 8);

    rd_state_t         state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  total;
    logic [LEN_W-1:0]  consumed;
    logic [CNT_W-1:0]  outstanding;

    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  len_c;
    logic [CNT_W-1:0]  free_words;
    logic              credit_ok;
    logic              burst_acc;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    assign len        = (remaining > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : remaining;
    assign len_c      = CNT_W'(len);
    assign free_words = CNT_W'(FIFO_DEPTH) - fifo_count - outstanding;
    assign credit_ok  = (free_words >= len_c);
    assign burst_acc  = (state == ISSUE) && credit_ok && !avm_waitrequest;
    // Strobes seen in IDLE belong to a command killed by reset and are dropped.
    assign push       = avm_readdatavalid && (state != IDLE) && !fifo_full;
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_n  = state;
        avm_read = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) state_n = (cmd_words == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                avm_read = credit_ok;
                if (burst_acc && (remaining == len)) state_n = DRAIN;
            end
            DRAIN: begin
                if ((outstanding == '0) && fifo_empty) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock_source or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            total       <= '0;
            consumed    <= '0;
            outstanding <= '0;
        end else begin
            state <= state_n;
            if ((state == IDLE) && cmd_valid) begin
                addr      <= cmd_base_addr;
                remaining <= cmd_words;
                total     <= cmd_words;
                consumed  <= '0;
            end else begin
                if (burst_acc) begin
                    addr      <= addr + (ADDR_W'(len) << SHIFT);
                    remaining <= remaining - len;
                end
                if (pop) consumed <= consumed + 1'b1;
            end
            outstanding <= outstanding + (burst_acc ? len_c : '0) - CNT_W'(push);
        end
    end

    line_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock_source),
        .rst_n (global_reset_n),
        .push  (push),
        .wdata (avm_readdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign avm_address    = addr;
    assign avm_burstcount = avm_read ? BC_W'(len) : '0;
    assign cmd_ready      = (state == IDLE);
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign out_valid      = !fifo_empty;
    assign out_data       = out_valid ? fifo_rdata : '0;
    assign out_last       = out_valid && ((consumed + 1'b1) == total);
endmodule

// File: tb/tb_ddr_line_reader.sv
// Directed bench for ddr_line_reader with a behavioural Avalon slave and a stream consumer.
module tb_ddr_line_reader;
    logic        clock_source = 1'b0;
    logic        global_reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_base_addr;
    logic [15:0] cmd_words;
    logic [23:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    always #5 clock_source = ~clock_source;

    ddr_line_reader dut (
        .clock_source      (clock_source),
        .global_reset_n    (global_reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_base_addr     (cmd_base_addr),
        .cmd_words         (cmd_words),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .busy              (busy),
        .done              (done)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] rq[$];
    int          log_addr[$];
    int          log_bc[$];
    int          log_start = 0;
    int          stall_idx = -1;
    int          stall_left = 0;
    logic [23:0] stall_addr_exp = '0;
    int          cmd_req = 0;
    int          word_idx = 0;
    int          last_cnt = 0;
    int          done_cnt = 0;
    int          cur_words = 0;
    logic [23:0] cur_base = '0;
    int          ready_mode = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return {8'hC3, a};
    endfunction

    // Avalon slave: decides waitrequest/readdatavalid for the coming rising edge.
    always @(negedge clock_source) begin
        if (!global_reset_n) begin
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
        end else begin
            if (rq.size() > 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem_word(rq.pop_front());
            end else begin
                avm_readdatavalid = 1'b0;
            end
            avm_waitrequest = 1'b0;
            if (avm_read) begin
                if ((log_addr.size() - log_start == stall_idx) && (stall_left > 0)) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                    chk("stall_addr_held", 32'(avm_address), 32'(stall_addr_exp));
                    chk("stall_bc_held", 32'(avm_burstcount), 32'd8);
                end else begin
                    log_addr.push_back(int'(avm_address));
                    log_bc.push_back(int'(avm_burstcount));
                    cmd_req += int'(avm_burstcount);
                    chk("credit_limit", 32'(cmd_req - word_idx <= 32), 32'd1);
                    for (int k = 0; k < int'(avm_burstcount); k++)
                        rq.push_back(avm_address + 24'(4 * k));
                end
            end
        end
    end

    // Stream consumer and scoreboard against the address-derived memory pattern.
    always @(negedge clock_source) begin
        if (ready_mode == 2) out_ready = ~out_ready;
        else                 out_ready = (ready_mode == 1);
        if (global_reset_n && out_valid && out_ready) begin
            chk("stream_data", out_data, mem_word(cur_base + 24'(4 * word_idx)));
            chk("stream_last", 32'(out_last), 32'(word_idx == cur_words - 1));
            if (out_last) last_cnt++;
            word_idx++;
        end
        if (done) done_cnt++;
    end

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({pfx, "_avm_read"}, 32'(avm_read), 32'd0);
        chk({pfx, "_avm_address"}, 32'(avm_address), 32'd0);
        chk({pfx, "_avm_bc"}, 32'(avm_burstcount), 32'd0);
        chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({pfx, "_out_data"}, out_data, 32'd0);
        chk({pfx, "_out_last"}, 32'(out_last), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic send(input logic [23:0] base, input int words);
        @(negedge clock_source);
        word_idx  = 0;
        cmd_req   = 0;
        last_cnt  = 0;
        done_cnt  = 0;
        cur_words = words;
        cur_base  = base;
        log_start = log_addr.size();
        chk("send_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("send_idle_busy", 32'(busy), 32'd0);
        cmd_valid     = 1'b1;
        cmd_base_addr = base;
        cmd_words     = 16'(words);
        @(negedge clock_source);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 1000) begin
            @(negedge clock_source);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clock_source);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_busy_clear"}, 32'(busy), 32'd0);
        chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_words_out"}, 32'(word_idx), 32'(cur_words));
        chk({tag, "_last_count"}, 32'(last_cnt), 32'(cur_words > 0 ? 1 : 0));
    endtask

    task automatic chk_burst(input string tag, input int i, input int a, input int bc);
        chk({tag, "_addr"}, 32'(log_addr[log_start + i]), 32'(a));
        chk({tag, "_bc"}, 32'(log_bc[log_start + i]), 32'(bc));
    endtask

    initial begin
        global_reset_n    = 1'b0;
        cmd_valid         = 1'b0;
        cmd_base_addr     = '0;
        cmd_words         = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        out_ready         = 1'b0;
        #3;
        chk_reset_vals("rst");
        repeat (2) @(negedge clock_source);
        global_reset_n = 1'b1;

        // Basic 20-word fetch: bursts of 8, 8, 4.
        ready_mode = 1;
        send(24'h001000, 20);
        wait_done("basic");
        chk("basic_nbursts", 32'(log_addr.size() - log_start), 32'd3);
        chk_burst("basic_b0", 0, 'h1000, 8);
        chk_burst("basic_b1", 1, 'h1020, 8);
        chk_burst("basic_b2", 2, 'h1040, 4);

        // Backpressure: only FIFO_DEPTH words may be requested while nothing drains.
        ready_mode = 0;
        send(24'h002000, 64);
        repeat (80) @(negedge clock_source);
        #1;
        chk("bp_requested", 32'(cmd_req), 32'd32);
        chk("bp_nbursts", 32'(log_addr.size() - log_start), 32'd4);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        ready_mode = 1;
        wait_done("bp");
        chk("bp_total_req", 32'(cmd_req), 32'd64);

        // Slave stalls the second burst for three cycles.
        stall_idx      = 1;
        stall_left     = 3;
        stall_addr_exp = 24'h001020;
        send(24'h001000, 16);
        wait_done("stall");
        stall_idx = -1;
        chk("stall_consumed", 32'(stall_left), 32'd0);
        chk("stall_nbursts", 32'(log_addr.size() - log_start), 32'd2);
        chk_burst("stall_b0", 0, 'h1000, 8);
        chk_burst("stall_b1", 1, 'h1020, 8);

        // Zero-length command: done the cycle after accept, no reads.
        send(24'h004000, 0);
        #1;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("zero_avm_read", 32'(avm_read), 32'd0);
        @(negedge clock_source);
        #1;
        chk("zero_done_off", 32'(done), 32'd0);
        chk("zero_busy_off", 32'(busy), 32'd0);
        chk("zero_cmd_ready_back", 32'(cmd_ready), 32'd1);
        chk("zero_nbursts", 32'(log_addr.size() - log_start), 32'd0);

        // Single word with a toggling consumer.
        ready_mode = 2;
        send(24'h005004, 1);
        wait_done("tail");
        chk("tail_nbursts", 32'(log_addr.size() - log_start), 32'd1);
        chk_burst("tail_b0", 0, 'h5004, 1);
        chk("tail_out_valid", 32'(out_valid), 32'd0);

        // Reset after ten words of a 40-word line.
        ready_mode = 1;
        send(24'h003000, 40);
        begin
            int n = 0;
            while (word_idx < 10 && n < 500) begin
                @(negedge clock_source);
                n++;
            end
        end
        chk("mid_reached_10", 32'(word_idx >= 10), 32'd1);
        #2;
        global_reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        repeat (2) @(negedge clock_source);
        global_reset_n = 1'b1;
        begin
            int n = 0;
            while (rq.size() > 0 && n < 200) begin
                @(negedge clock_source);
                n++;
            end
        end
        chk("mid_stray_drained", 32'(rq.size()), 32'd0);
        @(negedge clock_source);
        #1;
        chk("mid_stray_discarded", 32'(out_valid), 32'd0);
        chk("mid_idle_busy", 32'(busy), 32'd0);
        chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);

        // Fresh command across the top of the address space.
        send(24'hFFFFF0, 12);
        wait_done("wrap");
        chk("wrap_nbursts", 32'(log_addr.size() - log_start), 32'd2);
        chk_burst("wrap_b0", 0, 'hFFFFF0, 8);
        chk_burst("wrap_b1", 1, 'h000010, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
